// File: rtl/softermax_norm_scheduler.sv
// softermax_norm_scheduler
// Row-level admission and sequencing controller for the softermax global
// normalization datapath. It sees only handshakes and flags; no data passes
// through it.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   up_valid/up_ready   upstream beat handshake; up_last marks a row's last beat
//   dp_in_valid/ready   gated beat handshake into the datapath
//   dp_out_valid/ready  datapath output handshake (passed straight through)
//   out_valid/ready     downstream handshake; out_last/out_row_id tag each beat
//   flush/flush_done    drain request and one-cycle completion pulse
//   rows_in_flight      admitted rows whose last output beat has not left yet
//   err                 sticky protocol error
//
// Handshake semantics: a beat transfers on a rising edge where valid and
// ready are both 1. A valid, once raised, is held with its beat until it
// transfers; ready may be asserted independently of valid.
//
// Optional feature: define SOFTERMAX_NORM_SCHED_CHECK_EN to build the
// protocol checker that drives err. Without it err is tied to 0 and
// up_last is ignored.

module softermax_norm_scheduler #(
  parameter int TOTAL_DIM    = 16,
  parameter int PARALLELISM  = 4,
  parameter int MAX_ROWS     = 4,
  parameter int ROW_ID_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              up_valid,
  input  logic                              up_last,
  output logic                              up_ready,
  output logic                              dp_in_valid,
  input  logic                              dp_in_ready,
  input  logic                              dp_out_valid,
  output logic                              dp_out_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [ROW_ID_WIDTH-1:0]           out_row_id,
  input  logic                              flush,
  output logic                              flush_done,
  output logic [$clog2(MAX_ROWS+1)-1:0]     rows_in_flight,
  output logic                              err
);

  localparam int DEPTH = TOTAL_DIM / PARALLELISM;
  localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW    = $clog2(MAX_ROWS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [RW-1:0] ROWS_MAX = RW'(MAX_ROWS);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t        state;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic          admit;
  logic          in_hs;
  logic          out_hs;
  logic          row_start;
  logic          row_end;

  // Mid-row beats always pass; a row start needs RUN and a free credit.
  // Only registered state feeds admit, so out_ready never reaches up_ready.
  assign admit       = (in_cnt != '0) | ((state == ST_RUN) & (rows_in_flight < ROWS_MAX));
  assign dp_in_valid = up_valid & admit;
  assign up_ready    = dp_in_ready & admit;

  assign out_valid    = dp_out_valid;
  assign dp_out_ready = out_ready;
  assign out_last     = (out_cnt == CNT_LAST);

  assign in_hs     = up_valid & up_ready;
  assign out_hs    = out_valid & out_ready;
  assign row_start = in_hs & (in_cnt == '0);
  assign row_end   = out_hs & out_last;

  // Beat position counters. With DEPTH == 1 CNT_LAST is 0, so both stay at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_hs)  in_cnt  <= (in_cnt  == CNT_LAST) ? '0 : in_cnt  + CW'(1);
      if (out_hs) out_cnt <= (out_cnt == CNT_LAST) ? '0 : out_cnt + CW'(1);
    end
  end

  // Row credit and output tag. Decrement saturates at 0; increment is bounded
  // by admission but still clamped to MAX_ROWS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows_in_flight <= '0;
      out_row_id     <= '0;
    end else begin
      if (row_start && !row_end) begin
        if (rows_in_flight != ROWS_MAX) rows_in_flight <= rows_in_flight + RW'(1);
      end else if (row_end && !row_start) begin
        if (rows_in_flight != '0) rows_in_flight <= rows_in_flight - RW'(1);
      end
      if (row_end) out_row_id <= out_row_id + ROW_ID_WIDTH'(1);
    end
  end

  // Drain sequencer. flush_done is registered and high exactly in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RUN;
      flush_done <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          flush_done <= 1'b0;
          if (flush) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (rows_in_flight == '0 && in_cnt == '0) begin
            state      <= ST_DONE;
            flush_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state      <= ST_RUN;
          flush_done <= 1'b0;
        end
        default: begin
          state      <= ST_RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef SOFTERMAX_NORM_SCHED_CHECK_EN
  // Flags a last marker on the wrong beat, or an output beat with no row open.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((in_hs && (up_last != (in_cnt == CNT_LAST))) ||
                 (out_hs && (rows_in_flight == '0))) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_up_last;
  assign unused_up_last = up_last;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_softermax_norm_scheduler.sv
// Testbench for softermax_norm_scheduler (default parameters: DEPTH=4,
// MAX_ROWS=4, 4-bit row id). A behavioural model tracks accepted/output beat
// totals and a queue of open row tags; every cycle the DUT outputs are
// compared against it, plus directed scenario checks.

module tb_softermax_norm_scheduler;

  localparam int DEPTH    = 4;
  localparam int MAX_ROWS = 4;

  logic       clk;
  logic       rst;
  logic       up_valid;
  logic       up_last;
  logic       up_ready;
  logic       dp_in_valid;
  logic       dp_in_ready;
  logic       dp_out_valid;
  logic       dp_out_ready;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [3:0] out_row_id;
  logic       flush;
  logic       flush_done;
  logic [2:0] rows_in_flight;
  logic       err;

  softermax_norm_scheduler #(
    .TOTAL_DIM(16), .PARALLELISM(4), .MAX_ROWS(MAX_ROWS), .ROW_ID_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_last(up_last), .up_ready(up_ready),
    .dp_in_valid(dp_in_valid), .dp_in_ready(dp_in_ready),
    .dp_out_valid(dp_out_valid), .dp_out_ready(dp_out_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_row_id(out_row_id),
    .flush(flush), .flush_done(flush_done),
    .rows_in_flight(rows_in_flight), .err(err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef SOFTERMAX_NORM_SCHED_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // ---------------- scoreboard / model ----------------
  logic [3:0] exp_q[$];   // tags of admitted rows not yet fully output
  int         acc_beats;  // beats accepted since reset
  int         out_beats;  // beats output since reset
  int         mode;       // 0 running, 1 draining, 2 drain complete
  logic [3:0] next_tag;
  logic       err_m;

  int n_checks;
  int n_fail;

  // observations for directed checks
  int   obs_acc;
  int   fd_cnt;
  logic last_up_ready;
  logic last_out_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    acc_beats = 0;
    out_beats = 0;
    mode      = 0;
    next_tag  = '0;
    err_m     = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    up_valid = 0; up_last = 0; dp_in_ready = 0;
    dp_out_valid = 0; out_ready = 0; flush = 0;
    model_clear();
    #1;
    check_eq("rst_rows", 32'(rows_in_flight), 0);
    check_eq("rst_row_id", 32'(out_row_id), 0);
    check_eq("rst_flush_done", 32'(flush_done), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_up_ready", 32'(up_ready), 0);
    check_eq("rst_dp_in_valid", 32'(dp_in_valid), 0);
    check_eq("rst_out_last", 32'(out_last), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
  endtask

  // One cycle: drive at negedge, check against the model, advance model at posedge.
  task automatic step(input logic uv, input logic dir, input logic dov,
                      input logic ordy, input logic fl, input logic bad_last);
    int   in_pos;
    int   out_pos;
    int   rif;
    logic admit_m;
    logic dov_eff;
    logic in_hs;
    logic out_hs;
    logic [3:0] tag_exp;
    @(negedge clk);
    in_pos  = acc_beats % DEPTH;
    out_pos = out_beats % DEPTH;
    rif     = exp_q.size();
    admit_m = (in_pos != 0) || (mode == 0 && rif < MAX_ROWS);
    dov_eff = dov && (out_beats < acc_beats);   // datapath only emits what it holds
    tag_exp = (rif > 0) ? exp_q[0] : next_tag;

    up_valid     = uv;
    up_last      = (in_pos == DEPTH - 1) ^ bad_last;
    dp_in_ready  = dir;
    dp_out_valid = dov_eff;
    out_ready    = ordy;
    flush        = fl;
    #1;
    check_eq("up_ready", 32'(up_ready), 32'(dir & admit_m));
    check_eq("dp_in_valid", 32'(dp_in_valid), 32'(uv & admit_m));
    check_eq("out_valid", 32'(out_valid), 32'(dov_eff));
    check_eq("dp_out_ready", 32'(dp_out_ready), 32'(ordy));
    check_eq("out_last", 32'(out_last), 32'(out_pos == DEPTH - 1));
    check_eq("out_row_id", 32'(out_row_id), 32'(tag_exp));
    check_eq("rows_in_flight", 32'(rows_in_flight), 32'(rif));
    check_eq("flush_done", 32'(flush_done), 32'(mode == 2));
    check_eq("err", 32'(err), 32'(err_m));
    if (uv && up_ready) obs_acc++;
    if (flush_done) fd_cnt++;
    last_up_ready = up_ready;
    last_out_last = out_last;

    @(posedge clk);
    in_hs  = uv && dir && admit_m;
    out_hs = dov_eff && ordy;
    case (mode)
      0: if (fl) mode = 1;
      1: if (rif == 0 && in_pos == 0) mode = 2;
      default: mode = 0;
    endcase
    if (CHECK_EN) begin
      if (in_hs && (up_last != (in_pos == DEPTH - 1))) err_m = 1'b1;
      if (out_hs && rif == 0) err_m = 1'b1;
    end
    if (out_hs && out_pos == DEPTH - 1) void'(exp_q.pop_front());
    if (in_hs && in_pos == 0) begin
      exp_q.push_back(next_tag);
      next_tag = next_tag + 4'd1;
    end
    if (in_hs) acc_beats++;
    if (out_hs) out_beats++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0);
  endtask

  task automatic drain_out(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 1, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    obs_acc  = 0;
    fd_cnt   = 0;
    rst = 1'b1;
    up_valid = 0; up_last = 0; dp_in_ready = 0;
    dp_out_valid = 0; out_ready = 0; flush = 0;
    model_clear();
    #2;
    do_reset();

    // Credit limit: 20 offered beats, only 4 rows' worth accepted.
    obs_acc = 0;
    feed(20);
    check_eq("credit_acc16", 32'(obs_acc), 16);
    check_eq("credit_up_ready_blocked", 32'(last_up_ready), 0);
    #1;
    check_eq("credit_rows4", 32'(rows_in_flight), 4);

    // Drain one row while upstream keeps offering; credit usable next cycle.
    obs_acc = 0;
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0, 0);
    check_eq("drain_last_on_4th", 32'(last_out_last), 1);
    check_eq("drain_no_same_cycle_admit", 32'(obs_acc), 0);
    #1;
    check_eq("drain_row_id1", 32'(out_row_id), 1);
    check_eq("drain_rows3", 32'(rows_in_flight), 3);
    obs_acc = 0;
    feed(4);
    check_eq("resume_acc4", 32'(obs_acc), 4);

    // Row start and row end in the same cycle.
    do_reset();
    feed(4);
    drain_out(3);
    step(1, 1, 1, 1, 0, 0);
    #1;
    check_eq("same_cycle_rows1", 32'(rows_in_flight), 1);

    // Flush mid-row: finish the row, block the next start, pulse once.
    do_reset();
    feed(2);
    step(1, 1, 0, 0, 1, 0);
    obs_acc = 0;
    step(1, 1, 0, 0, 0, 0);
    check_eq("flush_row_completes", 32'(obs_acc), 1);
    step(1, 1, 0, 0, 0, 0);
    check_eq("flush_start_blocked", 32'(last_up_ready), 0);
    fd_cnt = 0;
    drain_out(10);
    check_eq("flush_done_once", 32'(fd_cnt), 1);
    step(1, 1, 0, 0, 0, 0);
    check_eq("flush_resume", 32'(last_up_ready), 1);

    // Flush while idle: pulse two cycles after sampling.
    do_reset();
    step(0, 0, 0, 0, 1, 0);
    idle(4);

    // Misplaced last marker.
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    idle(1);
    check_eq("err_set", 32'(err), 32'(CHECK_EN));
    idle(3);
    check_eq("err_sticky", 32'(err), 32'(CHECK_EN));

    // Reset with rows in flight, then first row restarts at tag 0.
    do_reset();
    feed(12);
    do_reset();
    feed(4);
    #1;
    check_eq("post_rst_row_id0", 32'(out_row_id), 0);
    drain_out(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0, 1'b0);
    end
    drain_out(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
